// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO family: read-mode encodings, pointer sizing
// and parameter-legality helpers checked at elaboration.
package fifo_pkg;

  localparam int MODE_REGISTERED = 0;
  localparam int MODE_FWFT       = 1;

  // Pointer width: one extra MSB beyond the address so full and empty differ on wrap.
  function automatic int ptrWidth(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit depthLegal(input int depth);
    return (depth >= 4) && ((depth & (depth - 1)) == 0);
  endfunction

  function automatic bit afLegal(input int afThresh, input int depth);
    return (afThresh >= 1) && (afThresh <= depth);
  endfunction

  function automatic bit aeLegal(input int aeThresh, input int depth);
    return (aeThresh >= 0) && (aeThresh <= depth - 1);
  endfunction

  function automatic bit modeLegal(input int fwft);
    return (fwft == MODE_REGISTERED) || (fwft == MODE_FWFT);
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// WIDTH x DEPTH register array: one synchronous write port, one asynchronous
// read port. Shared with the dual-clock FIFO.
module fifo_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     Clk,
  input  logic                     writeEn,
  input  logic [$clog2(DEPTH)-1:0] writeAddr,
  input  logic [WIDTH-1:0]         writeData,
  input  logic [$clog2(DEPTH)-1:0] readAddr,
  output logic [WIDTH-1:0]         readData
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Store the write word; storage content is undefined after reset.
  // NOTE: the array has no reset on purpose -- resetting it would turn a plain
  // register file into DEPTH*WIDTH reset flops; pointers alone define validity.
  always_ff @(posedge Clk) begin
    if (writeEn) mem[writeAddr] <= writeData;
  end

  assign readData = mem[readAddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with registered or first-word-fall-through read, occupancy
// count, almost-full/empty thresholds and sticky overflow/underflow flags.
module sync_fifo_param #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = 12,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic                     Clk,
  input  logic                     reset,
  input  logic                     ControlIn,
  input  logic [WIDTH-1:0]         dataIn,
  output logic                     haltInput,
  input  logic                     ReadEn,
  output logic [WIDTH-1:0]         dataOut,
  output logic                     dataValid,
  output logic                     empty,
  output logic                     almostFull,
  output logic                     almostEmpty,
  output logic [$clog2(DEPTH):0]   fillLevel,
  output logic                     overflow,
  output logic                     underflow,
  input  logic                     ClearFlags
);

  import fifo_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int PW = ptrWidth(DEPTH);

  if (!depthLegal(DEPTH)) begin : gDepthCheck
    $error("sync_fifo_param: DEPTH must be a power of two and >= 4");
  end
  if (!afLegal(AF_THRESH, DEPTH)) begin : gAfCheck
    $error("sync_fifo_param: AF_THRESH must be in 1..DEPTH");
  end
  if (!aeLegal(AE_THRESH, DEPTH)) begin : gAeCheck
    $error("sync_fifo_param: AE_THRESH must be in 0..DEPTH-1");
  end
  if (!modeLegal(FWFT) || WIDTH < 1) begin : gModeCheck
    $error("sync_fifo_param: FWFT must be 0 or 1 and WIDTH >= 1");
  end

  logic [PW-1:0]    wPtr, rPtr, wPtrNext, rPtrNext, fillNext;
  logic             writeAccept, readAccept, emptyNext, fullNext;
  logic             dataValidNext;
  logic [WIDTH-1:0] dataOutNext, ramReadData;
  logic [AW-1:0]    ramReadAddr;

  // FWFT presents the word at the post-pop read pointer; registered mode reads the current head.
  assign ramReadAddr = (FWFT == MODE_FWFT) ? rPtrNext[AW-1:0] : rPtr[AW-1:0];

  fifo_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) uRam (
    .Clk       (Clk),
    .writeEn   (writeAccept),
    .writeAddr (wPtr[AW-1:0]),
    .writeData (dataIn),
    .readAddr  (ramReadAddr),
    .readData  (ramReadData)
  );

  // Next-state for pointers, occupancy, full/empty and read data.
  // NOTE: every signal gets a default at the top so no path leaves it unassigned (no latch).
  always_comb begin
    writeAccept   = ControlIn && !haltInput;
    readAccept    = ReadEn && !empty;
    wPtrNext      = wPtr + PW'(writeAccept);
    rPtrNext      = rPtr + PW'(readAccept);
    fillNext      = fillLevel;
    case ({writeAccept, readAccept})
      2'b10:   fillNext = fillLevel + PW'(1);
      2'b01:   fillNext = fillLevel - PW'(1);
      default: fillNext = fillLevel;
    endcase
    emptyNext     = (wPtrNext == rPtrNext);
    fullNext      = (wPtrNext[AW-1:0] == rPtrNext[AW-1:0]) && (wPtrNext[AW] != rPtrNext[AW]);
    dataOutNext   = dataOut;
    dataValidNext = 1'b0;
    if (FWFT == MODE_FWFT) begin
      // A word written into the slot that becomes the head bypasses the array.
      dataOutNext   = (writeAccept && (wPtr == rPtrNext)) ? dataIn : ramReadData;
      dataValidNext = !emptyNext;
    end else begin
      if (readAccept) dataOutNext = ramReadData;
      dataValidNext = readAccept;
    end
  end

  // Register pointers, flags and output data together so all track the post-edge state.
  // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      wPtr        <= '0;
      rPtr        <= '0;
      empty       <= 1'b1;
      haltInput   <= 1'b0;
      fillLevel   <= '0;
      almostFull  <= 1'b0;
      almostEmpty <= 1'b1;
      dataOut     <= '0;
      dataValid   <= 1'b0;
    end else begin
      wPtr        <= wPtrNext;
      rPtr        <= rPtrNext;
      empty       <= emptyNext;
      haltInput   <= fullNext;
      fillLevel   <= fillNext;
      almostFull  <= (fillNext >= PW'(AF_THRESH));
      almostEmpty <= (fillNext <= PW'(AE_THRESH));
      dataOut     <= dataOutNext;
      dataValid   <= dataValidNext;
    end
  end

  // Sticky error flags; a new error in the same cycle beats ClearFlags.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ControlIn && haltInput) overflow <= 1'b1;
      else if (ClearFlags)        overflow <= 1'b0;
      if (ReadEn && empty)        underflow <= 1'b1;
      else if (ClearFlags)        underflow <= 1'b0;
    end
  end

endmodule
